// File: rtl/controle_multiciclo.sv
// Multi-cycle control FSM for the RV32 subset lw/sw/sub/xor/addi/srl/beq.
// Optional build macro PERF_COUNTERS_EN adds cycle and retired-instruction counters.
module controle_multiciclo #(
  parameter int INSTR_LIMIT = 7,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       estado,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic [3:0]       alu_ctrl,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             done,
  output logic [1:0]       erro,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_FIM  = 3'b110,
    S_IDLE = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE, OP_LW, OP_SW, OP_SUB, OP_XOR, OP_SRL, OP_ADDI, OP_BEQ
  } op_t;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  op_t               op_q, op_d, op_dec;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       ret_q, ret_d;
  logic [1:0]        erro_q, erro_d;
  logic              retire, start_go, limit_hit;

  // Handshake: start is a level sampled only in IDLE or FIM; done stays high
  // for every cycle in FIM and drops on the edge that accepts start.
  assign start_go  = start && (state_q == S_IDLE || state_q == S_FIM);
  assign limit_hit = (INSTR_LIMIT != 0) && (ret_q + 32'd1 == 32'(INSTR_LIMIT));

  always_comb begin
    op_dec = OP_NONE;
    case (opcode)
      7'b0000011: if (funct3 == 3'b010) op_dec = OP_LW;
      7'b0100011: if (funct3 == 3'b010) op_dec = OP_SW;
      7'b0010011: if (funct3 == 3'b000) op_dec = OP_ADDI;
      7'b1100011: if (funct3 == 3'b000) op_dec = OP_BEQ;
      7'b0110011: begin
        if (funct3 == 3'b000 && funct7_5)       op_dec = OP_SUB;
        else if (funct3 == 3'b100 && !funct7_5) op_dec = OP_XOR;
        else if (funct3 == 3'b101 && !funct7_5) op_dec = OP_SRL;
      end
      default: op_dec = OP_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    ret_d   = ret_q;
    erro_d  = erro_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE, S_FIM: begin
        if (start) begin
          state_d = S_IF;
          ret_d   = 32'd0;
          erro_d  = 2'b00;
        end
      end
      S_IF: state_d = S_ID;
      S_ID: begin
        op_d = op_dec;
        if (op_dec == OP_NONE) begin
          state_d = S_FIM;
          erro_d  = 2'b01;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (op_q == OP_BEQ) begin
          retire = 1'b1;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_LW) state_d = S_WB;
          else               retire  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FIM;
          erro_d  = 2'b10;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB:    retire  = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (retire) begin
      ret_d   = ret_q + 32'd1;
      state_d = limit_hit ? S_FIM : S_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      wait_q  <= '0;
      ret_q   <= 32'd0;
      erro_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
      erro_q  <= erro_d;
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_ctrl   = 4'b0000;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IF: ir_write = 1'b1;
      S_EX: begin
        alu_src = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_ADDI);
        case (op_q)
          OP_SUB, OP_BEQ: alu_ctrl = 4'b0001;
          OP_XOR:         alu_ctrl = 4'b0010;
          OP_SRL:         alu_ctrl = 4'b0011;
          default:        alu_ctrl = 4'b0000;
        endcase
        if (op_q == OP_BEQ) begin
          pc_write = 1'b1;
          pc_src   = zero;
        end
      end
      S_MEM: begin
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        pc_write  = (op_q == OP_SW) && mem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LW);
        pc_write   = 1'b1;
      end
      S_FIM:   done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  assign estado = state_q;
  assign erro   = erro_q;

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, rcnt_q, rcnt_d;

  always_comb begin
    cyc_d  = cyc_q;
    rcnt_d = rcnt_q;
    if (start_go) begin
      cyc_d  = '0;
      rcnt_d = '0;
    end else begin
      if (state_q != S_IDLE && state_q != S_FIM) cyc_d = cyc_q + CNT_W'(1);
      if (retire) rcnt_d = rcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q  <= '0;
      rcnt_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign cycle_count   = cyc_q;
  assign retired_count = rcnt_q;
`else
  assign cycle_count   = '0;
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: directed vector table, mid-access reset and
// randomized instruction streams checked cycle by cycle against an instruction-level model.
module tb_controle_multiciclo;

  localparam int LIMIT = 7;
  localparam int TMO   = 16;
  localparam int CW    = 32;
  localparam int W     = 18;

  localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EX = 3'b010, S_MEM = 3'b011,
                         S_WB = 3'b100, S_FIM = 3'b110, S_IDLE = 3'b111;

  localparam int K_LW = 0, K_SW = 1, K_SUB = 2, K_XOR = 3, K_SRL = 4, K_ADDI = 5,
                 K_BEQ = 6, K_ILL = 7;

  logic          clk, rst_n, start, funct7_5, zero, mem_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3, estado;
  logic          ir_write, pc_write, pc_src, alu_src, mem_read, mem_write;
  logic          mem_to_reg, reg_write, done;
  logic [3:0]    alu_ctrl;
  logic [1:0]    erro;
  logic [CW-1:0] cycle_count, retired_count;

  controle_multiciclo #(.INSTR_LIMIT(LIMIT), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready), .estado(estado),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .done(done), .erro(erro),
    .cycle_count(cycle_count), .retired_count(retired_count)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // model state
  logic [W-1:0] exp_q[$];
  bit           m_idle, m_fim;
  logic [1:0]   m_erro;
  int           m_ret, m_cycles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic irw, input logic pcw,
                                      input logic pcs, input logic asrc, input logic [3:0] actl,
                                      input logic mr, input logic mw, input logic m2r,
                                      input logic rw, input logic dn, input logic [1:0] er);
    return {st, irw, pcw, pcs, asrc, actl, mr, mw, m2r, rw, dn, er};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {estado, ir_write, pc_write, pc_src, alu_src, alu_ctrl,
            mem_read, mem_write, mem_to_reg, reg_write, done, erro};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (op == 7'b0000011 && f3 == 3'b010) return K_LW;
    if (op == 7'b0100011 && f3 == 3'b010) return K_SW;
    if (op == 7'b0010011 && f3 == 3'b000) return K_ADDI;
    if (op == 7'b1100011 && f3 == 3'b000) return K_BEQ;
    if (op == 7'b0110011 && f3 == 3'b000 && f7)  return K_SUB;
    if (op == 7'b0110011 && f3 == 3'b100 && !f7) return K_XOR;
    if (op == 7'b0110011 && f3 == 3'b101 && !f7) return K_SRL;
    return K_ILL;
  endfunction

  task automatic check_perf();
`ifdef PERF_COUNTERS_EN
    check("cycle_count", 64'(cycle_count), 64'(m_cycles));
    check("retired_count", 64'(retired_count), 64'(m_ret));
`else
    check("cycle_count", 64'(cycle_count), 64'd0);
    check("retired_count", 64'(retired_count), 64'd0);
`endif
  endtask

  // one clock: drive, compare outputs at negedge, advance model counters
  task automatic cycle_check(input logic [W-1:0] exp, input logic mr, input logic st,
                             input bit ret);
    mem_ready = mr;
    start     = st;
    exp_q.push_back(exp);
    @(negedge clk);
    check("ctl", 64'(dut_word()), 64'(exp_q.pop_front()));
    check_perf();
    @(posedge clk);
    #1;
    if (exp[17:15] != S_IDLE && exp[17:15] != S_FIM) m_cycles++;
    if (ret) m_ret++;
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] rest_word();
    return m_fim ? mk(S_FIM, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 1, m_erro)
                 : mk(S_IDLE, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 2'b00);
  endfunction

  task automatic do_start();
    cycle_check(rest_word(), rnd(), 1'b1, 1'b0);
    m_idle = 0; m_fim = 0; m_erro = 2'b00; m_ret = 0; m_cycles = 0;
  endtask

  task automatic after_retire();
    if (LIMIT != 0 && m_ret == LIMIT) m_fim = 1;
  endtask

  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input int waits, input logic z);
    int k;
    logic lw_i, sw_i, asrc, rdy;
    logic [3:0] actl;
    k = classify(op, f3, f7);
    if (m_idle || m_fim) do_start();
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
    cycle_check(mk(S_IF, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 2'b00), rnd(), rnd(), 0);
    cycle_check(mk(S_ID, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 2'b00), rnd(), rnd(), 0);
    if (k == K_ILL) begin
      m_fim = 1; m_erro = 2'b01;
      return;
    end
    lw_i = (k == K_LW);
    sw_i = (k == K_SW);
    asrc = lw_i || sw_i || (k == K_ADDI);
    case (k)
      K_SUB, K_BEQ: actl = 4'd1;
      K_XOR:        actl = 4'd2;
      K_SRL:        actl = 4'd3;
      default:      actl = 4'd0;
    endcase
    if (k == K_BEQ) begin
      cycle_check(mk(S_EX, 0, 1, z, asrc, actl, 0, 0, 0, 0, 0, 2'b00), rnd(), rnd(), 1);
      after_retire();
      return;
    end
    cycle_check(mk(S_EX, 0, 0, 0, asrc, actl, 0, 0, 0, 0, 0, 2'b00), rnd(), rnd(), 0);
    if (lw_i || sw_i) begin
      rdy = 1'b0;
      for (int i = 0; i < TMO && !rdy; i++) begin
        rdy = (i == waits);
        cycle_check(mk(S_MEM, 0, sw_i && rdy, 0, 0, 4'd0, lw_i, sw_i, 0, 0, 0, 2'b00),
                    rdy, rnd(), sw_i && rdy);
      end
      if (!rdy) begin
        m_fim = 1; m_erro = 2'b10;
        return;
      end
      if (sw_i) begin
        after_retire();
        return;
      end
    end
    cycle_check(mk(S_WB, 0, 1, 0, 0, 4'd0, 0, 0, lw_i, 1, 0, 2'b00), rnd(), rnd(), 1);
    after_retire();
  endtask

  task automatic apply_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    mem_ready = 1'b0;
    #2;
    check("reset_ctl", 64'(dut_word()), 64'(mk(S_IDLE, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 2'b00)));
    check("reset_cyc", 64'(cycle_count), 64'd0);
    check("reset_ret", 64'(retired_count), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_idle = 1; m_fim = 0; m_erro = 2'b00; m_ret = 0; m_cycles = 0;
    exp_q.delete();
  endtask

  task automatic gen_fields(input int k, output logic [6:0] op, output logic [2:0] f3,
                            output logic f7);
    f7 = rnd();
    case (k)
      K_LW:   begin op = 7'b0000011; f3 = 3'b010; end
      K_SW:   begin op = 7'b0100011; f3 = 3'b010; end
      K_ADDI: begin op = 7'b0010011; f3 = 3'b000; end
      K_BEQ:  begin op = 7'b1100011; f3 = 3'b000; end
      K_SUB:  begin op = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
      K_XOR:  begin op = 7'b0110011; f3 = 3'b100; f7 = 1'b0; end
      K_SRL:  begin op = 7'b0110011; f3 = 3'b101; f7 = 1'b0; end
      default: begin
        do begin
          op = 7'($urandom); f3 = 3'($urandom); f7 = rnd();
        end while (classify(op, f3, f7) != K_ILL);
      end
    endcase
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    int         waits;
    logic       z;
    logic [2:0] exp_st;
    logic [1:0] exp_er;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    int k, waits;

    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;
    start = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;

    vecs[0]  = '{7'b0010011, 3'b000, 1'b0, 0,  1'b0, S_IF,  2'b00}; // addi
    vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 0,  1'b0, S_IF,  2'b00}; // sub
    vecs[2]  = '{7'b0110011, 3'b100, 1'b0, 0,  1'b0, S_IF,  2'b00}; // xor
    vecs[3]  = '{7'b0110011, 3'b101, 1'b0, 0,  1'b0, S_IF,  2'b00}; // srl
    vecs[4]  = '{7'b0000011, 3'b010, 1'b0, 3,  1'b0, S_IF,  2'b00}; // lw, 3 waits
    vecs[5]  = '{7'b1100011, 3'b000, 1'b0, 0,  1'b1, S_IF,  2'b00}; // beq taken
    vecs[6]  = '{7'b1100011, 3'b000, 1'b0, 0,  1'b0, S_FIM, 2'b00}; // beq, 7th retire
    vecs[7]  = '{7'b0100011, 3'b010, 1'b0, 0,  1'b0, S_IF,  2'b00}; // sw
    vecs[8]  = '{7'b0100011, 3'b010, 1'b0, 99, 1'b0, S_FIM, 2'b10}; // sw timeout
    vecs[9]  = '{7'b1111111, 3'b000, 1'b0, 0,  1'b0, S_FIM, 2'b01}; // illegal
    for (int i = 10; i < 16; i++) vecs[i] = '{7'b0010011, 3'b000, 1'b0, 0, 1'b0, S_IF, 2'b00};
    vecs[16] = '{7'b0010011, 3'b000, 1'b0, 0, 1'b0, S_FIM, 2'b00};

    apply_reset();

    for (int i = 0; i < 17; i++) begin
      exec_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].waits, vecs[i].z);
      check("vec_state", 64'(estado), 64'(vecs[i].exp_st));
      check("vec_erro", 64'(erro), 64'(vecs[i].exp_er));
      check("vec_done", 64'(done), 64'(vecs[i].exp_st == S_FIM));
    end
    cycle_check(rest_word(), rnd(), 1'b0, 1'b0);

    // reset asserted while an lw is waiting in MEM
    do_start();
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    cycle_check(mk(S_IF, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 2'b00), 1'b1, 1'b0, 0);
    cycle_check(mk(S_ID, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, 0);
    cycle_check(mk(S_EX, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, 0);
    cycle_check(mk(S_MEM, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, 0);
    cycle_check(mk(S_MEM, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0, 0, 2'b00), 1'b0, 1'b0, 0);
    apply_reset();

    // randomized instruction streams
    for (int n = 0; n < 250; n++) begin
      if (m_fim && rnd()) cycle_check(rest_word(), rnd(), 1'b0, 1'b0);
      k = $urandom_range(0, 7);
      gen_fields(k, op, f3, f7);
      waits = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 4);
      exec_instr(op, f3, f7, waits, rnd());
    end
    cycle_check(rest_word(), rnd(), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
